// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared constants, FSM encoding and buffer entry type for the grid reader
package grid_pkg;
   localparam int GRID_SIZE   = 28;
   localparam int GRID_PIXELS = GRID_SIZE * GRID_SIZE;
   localparam int ADDR_W      = 10;
   localparam int PIX_W       = 8;
   localparam int RC_W        = 5;

   localparam logic [PIX_W-1:0] PIX_ON  = 8'hFF;
   localparam logic [PIX_W-1:0] PIX_OFF = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic              px;
      logic [ADDR_W-1:0] index;
      logic [RC_W-1:0]   row;
      logic [RC_W-1:0]   col;
      logic              last;
   } pix_t;
endpackage

// File: rtl/grid_skid_buffer.sv
// rtl/grid_skid_buffer.sv - 2-entry FIFO of tagged pixels between the memory return and the stream
module grid_skid_buffer
   import grid_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       push,
   input  pix_t       push_data,
   input  logic       pop,
   output pix_t       head,
   output logic       valid,
   output logic [1:0] count
);
   pix_t entry [2];
   logic wr_ptr;
   logic rd_ptr;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         entry[0] <= '0;
         entry[1] <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
      end else begin
         if (push) begin
            entry[wr_ptr] <= push_data;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head  = entry[rd_ptr];
   assign valid = (count != 2'd0);
endmodule

// File: rtl/grid_reader.sv
// rtl/grid_reader.sv - streams the 28x28 pixel memory row-major; optional GRID_READER_POPCOUNT_EN
module grid_reader
   import grid_pkg::*;
(
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic [RC_W-1:0]   out_row,
   output logic [RC_W-1:0]   out_col,
   output logic              out_last
`ifdef GRID_READER_POPCOUNT_EN
   ,
   output logic [ADDR_W-1:0] popcount
`endif
);
   state_t            state;
   state_t            state_n;
   logic              armed;
   logic [ADDR_W-1:0] addr;
   logic [RC_W-1:0]   row;
   logic [RC_W-1:0]   col;
   logic              inflight;
   pix_t              tag;
   pix_t              push_data;
   pix_t              head;
   logic              buf_valid;
   logic [1:0]        count;
   logic              pop;
   logic              addr_last;
   logic              credit_ok;

   assign pop       = buf_valid && out_ready;
   assign addr_last = (addr == ADDR_W'(GRID_PIXELS - 1));
   // Credit covers buffered plus returning pixels so a stalled consumer never overflows the buffer.
   assign credit_ok = (3'(count) + 3'(inflight)) < (3'd2 + 3'(pop));
   assign mem_rd_en = (state == ST_SCAN) && armed && credit_ok;
   assign mem_addr  = addr;

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (start) state_n = ST_SCAN;
         ST_SCAN:  if (mem_rd_en && addr_last) state_n = ST_DRAIN;
         ST_DRAIN: if (pop && head.last) state_n = ST_DONE;
         ST_DONE:  state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         armed    <= 1'b0;
         addr     <= '0;
         row      <= '0;
         col      <= '0;
         inflight <= 1'b0;
         tag      <= '0;
      end else begin
         state    <= state_n;
         armed    <= (state == ST_SCAN);
         inflight <= mem_rd_en;
         if (mem_rd_en) begin
            tag <= '{px: 1'b0, index: addr, row: row, col: col, last: addr_last};
         end
         if (state == ST_IDLE && start) begin
            addr <= '0;
            row  <= '0;
            col  <= '0;
         end else if (mem_rd_en) begin
            if (addr_last) begin
               addr <= '0;
               row  <= '0;
               col  <= '0;
            end else begin
               addr <= addr + 1'b1;
               if (col == RC_W'(GRID_SIZE - 1)) begin
                  col <= '0;
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      push_data    = tag;
      push_data.px = mem_rd_data;
   end

   grid_skid_buffer u_buf (
      .clk       (CLOCK_50),
      .resetn    (resetn),
      .push      (inflight),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .valid     (buf_valid),
      .count     (count)
   );

   assign busy      = (state == ST_SCAN) || (state == ST_DRAIN);
   assign done      = (state == ST_DONE);
   assign out_valid = buf_valid;
   assign out_data  = (buf_valid && head.px) ? PIX_ON : PIX_OFF;
   assign out_index = head.index;
   assign out_row   = head.row;
   assign out_col   = head.col;
   assign out_last  = buf_valid && head.last;

`ifdef GRID_READER_POPCOUNT_EN
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         popcount <= '0;
      end else if (state == ST_IDLE && start) begin
         popcount <= '0;
      end else if (pop && head.px) begin
         popcount <= popcount + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_grid_reader.sv
// tb/tb_grid_reader.sv - directed self-checking bench for grid_reader with a behavioural pixel memory
module tb_grid_reader;
   logic        CLOCK_50 = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, mem_rd_en;
   logic [9:0]  mem_addr;
   logic        mem_rd_data = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic [9:0]  out_index;
   logic [4:0]  out_row, out_col;
   logic        out_last;
`ifdef GRID_READER_POPCOUNT_EN
   logic [9:0]  popcount;
`endif

   logic        img [784];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          exp_idx = 0;
   int          rd_exp = 0;
   int          outst = 0;
   int          beats = 0;
   int          done_cnt = 0;
   logic        stall_q = 1'b0;
   logic [29:0] stall_snap = '0;

   grid_reader dut (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_index   (out_index),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_last    (out_last)
`ifdef GRID_READER_POPCOUNT_EN
      ,
      .popcount    (popcount)
`endif
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      cyc <= cyc + 1;
      if (mem_rd_en) mem_rd_data <= img[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] exp_beat(input int i);
      logic [7:0] d;
      d = img[i] ? 8'hFF : 8'h00;
      return {3'b0, 10'(i), 5'(i / 28), 5'(i % 28), d, (i == 783)};
   endfunction

   // Scoreboard: sampled on the falling edge, between active edges.
   always @(negedge CLOCK_50) begin
      if (!resetn) begin
         exp_idx = 0;
         rd_exp  = 0;
         outst   = 0;
         stall_q = 1'b0;
      end else begin
         if (start && !busy && !done) begin
            exp_idx = 0;
            rd_exp  = 0;
            outst   = 0;
         end
         if (stall_q)
            check("hold", {2'b0, out_valid, out_data, out_index, out_row, out_col, out_last},
                  {2'b0, stall_snap});
         if (mem_rd_en) begin
            check("rd_addr", {22'b0, mem_addr}, rd_exp);
            rd_exp++;
            outst++;
         end
         if (out_valid && out_ready) begin
            check("beat", {3'b0, out_index, out_row, out_col, out_data, out_last}, exp_beat(exp_idx));
            exp_idx++;
            outst--;
            beats++;
         end
         if (mem_rd_en) check("outstanding", outst > 2, 0);
         stall_q    = out_valid && !out_ready;
         stall_snap = {out_valid, out_data, out_index, out_row, out_col, out_last};
         if (done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   function automatic int img_ones();
      int n = 0;
      for (int i = 0; i < 784; i++) n += int'(img[i]);
      return n;
   endfunction

   task automatic check_pop(input string tag);
`ifdef GRID_READER_POPCOUNT_EN
      check(tag, {22'b0, popcount}, img_ones());
`else
      check(tag, {31'b0, busy}, 0);
`endif
   endtask

   // Start a scan, check the fixed start-up latency, then wait for done.
   task automatic run_scan(input string name, input bit rand_ready, input int exp_lat);
      int t0, b0;
      b0 = beats;
      start = 1'b1;
      tick();
      start = 1'b0;
      t0 = cyc;
      check({name, "_rd0"}, {30'b0, busy, mem_rd_en}, 2'b10);
      tick();
      check({name, "_rd1"}, {21'b0, mem_rd_en, mem_addr}, {21'b0, 1'b1, 10'd0});
      tick();
      check({name, "_v2"}, {31'b0, out_valid}, 0);
      tick();
      check({name, "_v3"}, {21'b0, out_valid, out_index}, {21'b0, 1'b1, 10'd0});
      for (int i = 0; i < 6000 && !done; i++) begin
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      check({name, "_done"}, {31'b0, done}, 1);
      if (exp_lat > 0) check({name, "_lat"}, cyc - t0, exp_lat);
      check({name, "_beats"}, beats - b0, 784);
      check_pop({name, "_pop"});
      out_ready = 1'b1;
      tick();
      check({name, "_idle"}, {30'b0, done, busy}, 0);
   endtask

   initial begin
      int d0, t0;
      for (int i = 0; i < 784; i++) img[i] = 1'b0;
      repeat (3) tick();
      check("rst_ctl", {28'b0, busy, done, mem_rd_en, out_valid}, 0);
      check("rst_out", {1'b0, mem_addr, out_data, out_index, out_last}, 0);
      check("rst_rc", {22'b0, out_row, out_col}, 0);
      resetn = 1'b1;
      tick();

      out_ready = 1'b1;
      run_scan("empty", 1'b0, 787);

      for (int r = 0; r < 28; r++) img[r * 29] = 1'b1;
      check("diag_ones", img_ones(), 28);
      run_scan("diag", 1'b0, 787);

      for (int i = 0; i < 784; i++) img[i] = 1'($urandom_range(0, 1));
      out_ready = 1'b0;
      run_scan("rand", 1'b1, 0);

      // Consumer stalled from the start: exactly two reads, head holds index 0.
      d0 = done_cnt;
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (100) tick();
      check("stall_head", {21'b0, out_valid, out_index}, {21'b0, 1'b1, 10'd0});
      check("stall_reads", rd_exp, 2);
      check("stall_nodone", done_cnt - d0, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 2000 && !done; i++) tick();
      check("stall_done", {31'b0, done}, 1);
      check("stall_lastidx", exp_idx, 784);
      check_pop("stall_pop");
      tick();

      // Reset in the middle of a scan.
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2000 && exp_idx < 400; i++) tick();
      check("rst_at400", exp_idx, 400);
      resetn = 1'b0;
      tick();
      check("midrst", {29'b0, out_valid, busy, done}, 0);
      resetn = 1'b1;
      tick();
      check("midrst_nodone", done_cnt - d0, 0);
      run_scan("rescan", 1'b0, 787);

      // start during SCAN and during DONE is ignored.
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      t0 = cyc;
      repeat (50) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) tick();
      check("ign_lat", cyc - t0, 787);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      check("ign_one_done", done_cnt - d0, 1);
      check("ign_idle", {30'b0, busy, mem_rd_en}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
